// File: rtl/fma_tv_pkg.sv
// Shared definitions for the fma16-family vector checker.
//   state_e        : checker FSM states
//   CTRL_*         : bit positions inside the 8-bit ctrl field
//   vec_width()    : total vector word width for a given FLEN/NF
//   off_*()        : LSB offsets of each field inside the vector word,
//                    packed MSB->LSB as {x, y, z, ctrl, rexp, flagsexp}
package fma_tv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned CTRL_W      = 8;
  localparam int unsigned CTRL_RM_LSB = 4;  // roundmode = ctrl[5:4]
  localparam int unsigned CTRL_MUL    = 3;
  localparam int unsigned CTRL_ADD    = 2;
  localparam int unsigned CTRL_NEGP   = 1;
  localparam int unsigned CTRL_NEGZ   = 0;

  function automatic int unsigned vec_width(input int unsigned flen, input int unsigned nf);
    return 3 * flen + CTRL_W + flen + nf;
  endfunction

  // flagsexp sits at bit 0; every other field stacks above it.
  function automatic int unsigned off_rexp(input int unsigned nf);
    return nf;
  endfunction

  function automatic int unsigned off_ctrl(input int unsigned flen, input int unsigned nf);
    return nf + flen;
  endfunction

  function automatic int unsigned off_z(input int unsigned flen, input int unsigned nf);
    return off_ctrl(flen, nf) + CTRL_W;
  endfunction

  function automatic int unsigned off_y(input int unsigned flen, input int unsigned nf);
    return off_z(flen, nf) + flen;
  endfunction

  function automatic int unsigned off_x(input int unsigned flen, input int unsigned nf);
    return off_y(flen, nf) + flen;
  endfunction

endpackage

// File: rtl/tv_delay.sv
// Delay line carrying the expected-value tag of each issued vector so it
// lines up with the DUT result LAT cycles later.
//   clk, reset : clock, synchronous active-high reset (clears valid bits)
//   valid_i    : vector live on the DUT ports this cycle
//   data_i     : tag {rexp, flagsexp, index}
//   valid_o    : tag at the compare point is live
//   data_o     : tag at the compare point
//   pending_o  : a live tag is still upstream of the compare point
module tv_delay #(
  parameter int unsigned LAT = 0,
  parameter int unsigned W   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         pending_o
);

  if (LAT == 0) begin : g_wire
    logic clk_rst_unused;
    assign clk_rst_unused = clk ^ reset;
    assign valid_o        = valid_i;
    assign data_o         = data_i;
    // With no stages the input already is the compare point.
    assign pending_o      = 1'b0;
  end else begin : g_pipe
    logic [LAT-1:0] v_q;
    logic [W-1:0]   d_q [LAT];

    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= '0;
      end else begin
        v_q[0] <= valid_i;
        for (int unsigned i = 1; i < LAT; i++) v_q[i] <= v_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      d_q[0] <= data_i;
      for (int unsigned i = 1; i < LAT; i++) d_q[i] <= d_q[i-1];
    end

    always_comb begin
      pending_o = valid_i;
      for (int unsigned i = 0; i + 1 < LAT; i++) pending_o = pending_o | v_q[i];
    end

    assign valid_o = v_q[LAT-1];
    assign data_o  = d_q[LAT-1];
  end

endmodule

// File: rtl/fma_vector_checker.sv
// Self-checking vector engine for fma16-family FMA units.
// Streams preloaded vectors into the DUT one per cycle, compares result and
// masked flags LAT cycles later, counts mismatches and captures the first one.
//   clk, reset          : clock, synchronous active-high reset
//   vec_wr_*            : vector RAM write port (ignored while busy)
//   num_vectors         : run length, sampled on start
//   flag_mask           : flag bits participating in the compare
//   stop_on_error       : stop issuing on first mismatch, sampled on start
//   start               : run request (ignored while busy)
//   x,y,z,roundmode,mul,add,negp,negz,dut_valid : DUT stimulus
//   result, flags       : DUT response
//   busy, done          : run status
//   errors, vec_count   : saturating mismatch count, vectors compared
//   first_err_*         : index and DUT outputs of the first mismatch
module fma_vector_checker
  import fma_tv_pkg::*;
#(
  parameter  int unsigned FLEN  = 16,
  parameter  int unsigned NF    = 4,
  parameter  int unsigned DEPTH = 1024,
  parameter  int unsigned LAT   = 0,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned VW    = vec_width(FLEN, NF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            vec_wr_en,
  input  logic [AW-1:0]   vec_wr_addr,
  input  logic [VW-1:0]   vec_wr_data,
  input  logic [AW:0]     num_vectors,
  input  logic [NF-1:0]   flag_mask,
  input  logic            stop_on_error,
  input  logic            start,
  output logic [FLEN-1:0] x,
  output logic [FLEN-1:0] y,
  output logic [FLEN-1:0] z,
  output logic [1:0]      roundmode,
  output logic            mul,
  output logic            add,
  output logic            negp,
  output logic            negz,
  output logic            dut_valid,
  input  logic [FLEN-1:0] result,
  input  logic [NF-1:0]   flags,
  output logic            busy,
  output logic            done,
  output logic [31:0]     errors,
  output logic [AW:0]     vec_count,
  output logic [AW-1:0]   first_err_idx,
  output logic [FLEN-1:0] first_err_result,
  output logic [NF-1:0]   first_err_flags
);

  localparam int unsigned OFF_REXP = off_rexp(NF);
  localparam int unsigned OFF_CTRL = off_ctrl(FLEN, NF);
  localparam int unsigned OFF_Z    = off_z(FLEN, NF);
  localparam int unsigned OFF_Y    = off_y(FLEN, NF);
  localparam int unsigned OFF_X    = off_x(FLEN, NF);
  localparam int unsigned TW       = FLEN + NF + AW;

  state_e state_q, state_d;

  logic [AW:0]     n_q;
  logic            stop_q;
  logic [AW-1:0]   addr_q;
  logic [VW-1:0]   mem [DEPTH];
  logic [VW-1:0]   rd_word;

  logic            rd_v_q;
  logic [FLEN-1:0] x_q, y_q, z_q, rexp_q;
  logic [5:0]      ctrl_q;
  logic [NF-1:0]   fexp_q;
  logic [AW-1:0]   idx_q;

  logic            cmp_v, pend;
  logic [TW-1:0]   cmp_tag;
  logic [FLEN-1:0] cmp_rexp;
  logic [NF-1:0]   cmp_fexp;
  logic [AW-1:0]   cmp_idx;

  logic [31:0]     errors_q;
  logic [AW:0]     cnt_q;
  logic [AW-1:0]   ferr_idx_q;
  logic [FLEN-1:0] ferr_res_q;
  logic [NF-1:0]   ferr_fl_q;

  logic            busy_int, start_ok, mismatch, rd_en, last;
  logic [1:0]      ctrl_hi_unused;

  assign busy_int = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign start_ok = start && !busy_int;
  assign last     = ({1'b0, addr_q} == (n_q - {{AW{1'b0}}, 1'b1}));

  // !== makes X/Z on the DUT result count as a mismatch in simulation.
  assign mismatch = cmp_v && ((result !== cmp_rexp) ||
                              (((flags ^ cmp_fexp) & flag_mask) != '0));

  // A stopping mismatch suppresses the read in the same cycle, so nothing
  // new enters the pipe once the first failure has been seen.
  assign rd_en = (state_q == ST_ISSUE) && !(stop_q && mismatch);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = (num_vectors == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE:         if ((stop_q && mismatch) || last) state_d = ST_DRAIN;
      ST_DRAIN:         if (!pend) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (vec_wr_en && !busy_int) mem[vec_wr_addr] <= vec_wr_data;
  end

  assign rd_word        = mem[addr_q];
  assign ctrl_hi_unused = rd_word[OFF_CTRL+6 +: 2];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_v_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      ctrl_q <= '0;
      rexp_q <= '0;
      fexp_q <= '0;
      idx_q  <= '0;
    end else begin
      rd_v_q <= rd_en;
      if (rd_en) begin
        x_q    <= rd_word[OFF_X +: FLEN];
        y_q    <= rd_word[OFF_Y +: FLEN];
        z_q    <= rd_word[OFF_Z +: FLEN];
        ctrl_q <= rd_word[OFF_CTRL +: 6];
        rexp_q <= rd_word[OFF_REXP +: FLEN];
        fexp_q <= rd_word[0 +: NF];
        idx_q  <= addr_q;
      end
    end
  end

  tv_delay #(
    .LAT (LAT),
    .W   (TW)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .valid_i   (rd_v_q),
    .data_i    ({rexp_q, fexp_q, idx_q}),
    .valid_o   (cmp_v),
    .data_o    (cmp_tag),
    .pending_o (pend)
  );

  assign {cmp_rexp, cmp_fexp, cmp_idx} = cmp_tag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      stop_q     <= 1'b0;
      addr_q     <= '0;
      errors_q   <= '0;
      cnt_q      <= '0;
      ferr_idx_q <= '0;
      ferr_res_q <= '0;
      ferr_fl_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        n_q        <= num_vectors;
        stop_q     <= stop_on_error;
        addr_q     <= '0;
        errors_q   <= '0;
        cnt_q      <= '0;
        ferr_idx_q <= '0;
        ferr_res_q <= '0;
        ferr_fl_q  <= '0;
      end else begin
        // Holding at N-1 keeps N = DEPTH from wrapping the address.
        if (rd_en && !last) addr_q <= addr_q + {{(AW-1){1'b0}}, 1'b1};
        if (cmp_v) begin
          cnt_q <= cnt_q + {{AW{1'b0}}, 1'b1};
          if (mismatch) begin
            if (errors_q != 32'hFFFF_FFFF) errors_q <= errors_q + 32'd1;
            if (errors_q == '0) begin
              ferr_idx_q <= cmp_idx;
              ferr_res_q <= result;
              ferr_fl_q  <= flags;
            end
          end
        end
      end
    end
  end

  assign x                = x_q;
  assign y                = y_q;
  assign z                = z_q;
  assign roundmode        = ctrl_q[CTRL_RM_LSB +: 2];
  assign mul              = ctrl_q[CTRL_MUL];
  assign add              = ctrl_q[CTRL_ADD];
  assign negp             = ctrl_q[CTRL_NEGP];
  assign negz             = ctrl_q[CTRL_NEGZ];
  assign dut_valid        = rd_v_q;
  assign busy             = busy_int;
  assign done             = (state_q == ST_DONE);
  assign errors           = errors_q;
  assign vec_count        = cnt_q;
  assign first_err_idx    = ferr_idx_q;
  assign first_err_result = ferr_res_q;
  assign first_err_flags  = ferr_fl_q;

endmodule

// File: tb/tb_fma_vector_checker.sv
// Directed bench for fma_vector_checker: one LAT=0 instance with a
// combinational stub DUT and one LAT=3 instance with a registered stub.
module tb_fma_vector_checker;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, wr_en0, wr_en3, stop_on_error, start0, start3;
  logic [AW-1:0] wr_addr;
  logic [75:0]   wr_data;
  logic [AW:0]   num_vectors;
  logic [3:0]    flag_mask;

  logic [15:0]   x0, y0, z0, res0, fres0, x3, y3, z3, res3, fres3;
  logic [1:0]    rm0, rm3;
  logic          mul0, add0, negp0, negz0, val0, busy0, done0;
  logic          mul3, add3, negp3, negz3, val3, busy3, done3;
  logic [3:0]    fl0, ffl0, fl3, ffl3;
  logic [31:0]   err0, err3;
  logic [AW:0]   cnt0, cnt3;
  logic [AW-1:0] fidx0, fidx3;

  fma_vector_checker #(.FLEN(16), .NF(4), .DEPTH(DEPTH), .LAT(0)) u_dut0 (
    .clk(clk), .reset(reset), .vec_wr_en(wr_en0), .vec_wr_addr(wr_addr),
    .vec_wr_data(wr_data), .num_vectors(num_vectors), .flag_mask(flag_mask),
    .stop_on_error(stop_on_error), .start(start0), .x(x0), .y(y0), .z(z0),
    .roundmode(rm0), .mul(mul0), .add(add0), .negp(negp0), .negz(negz0),
    .dut_valid(val0), .result(res0), .flags(fl0), .busy(busy0), .done(done0),
    .errors(err0), .vec_count(cnt0), .first_err_idx(fidx0),
    .first_err_result(fres0), .first_err_flags(ffl0));

  fma_vector_checker #(.FLEN(16), .NF(4), .DEPTH(DEPTH), .LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .vec_wr_en(wr_en3), .vec_wr_addr(wr_addr),
    .vec_wr_data(wr_data), .num_vectors(num_vectors), .flag_mask(flag_mask),
    .stop_on_error(stop_on_error), .start(start3), .x(x3), .y(y3), .z(z3),
    .roundmode(rm3), .mul(mul3), .add(add3), .negp(negp3), .negz(negz3),
    .dut_valid(val3), .result(res3), .flags(fl3), .busy(busy3), .done(done3),
    .errors(err3), .vec_count(cnt3), .first_err_idx(fidx3),
    .first_err_result(fres3), .first_err_flags(ffl3));

  // Stub FMA: exact for the two real test vectors, x^y^z otherwise,
  // with an optional override keyed on the x operand to plant an error.
  logic        ovr_en;
  logic [15:0] ovr_x, ovr_val;

  function automatic logic [15:0] stub_f(input logic [15:0] a, b, c);
    if (a == 16'h3c00 && b == 16'h3c00 && c == 16'h0000) return 16'h3c00;
    if (a == 16'h4000 && b == 16'h4200 && c == 16'h0000) return 16'h4600;
    return a ^ b ^ c;
  endfunction

  always_comb begin
    res0 = stub_f(x0, y0, z0);
    if (ovr_en && x0 == ovr_x) res0 = ovr_val;
  end
  assign fl0 = z0[3:0];

  logic [15:0] r3c;
  logic [19:0] p1, p2, p3;
  always_comb begin
    r3c = stub_f(x3, y3, z3);
    if (ovr_en && x3 == ovr_x) r3c = ovr_val;
  end
  always_ff @(posedge clk) begin
    p1 <= {r3c, z3[3:0]};
    p2 <= p1;
    p3 <= p2;
  end
  assign res3 = p3[19:4];
  assign fl3  = p3[3:0];

  // Per-run view of whichever instance is under test.
  logic          use3;
  logic          s_done, s_busy, s_val;
  logic [31:0]   s_err;
  logic [AW:0]   s_cnt;
  logic [AW-1:0] s_fidx;
  logic [15:0]   s_fres;
  logic [3:0]    s_ffl;
  assign s_done = use3 ? done3 : done0;
  assign s_busy = use3 ? busy3 : busy0;
  assign s_val  = use3 ? val3  : val0;
  assign s_err  = use3 ? err3  : err0;
  assign s_cnt  = use3 ? cnt3  : cnt0;
  assign s_fidx = use3 ? fidx3 : fidx0;
  assign s_fres = use3 ? fres3 : fres0;
  assign s_ffl  = use3 ? ffl3  : ffl0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] x, y, z;
    logic [7:0]  ctrl;
    logic [15:0] rexp;
    logic [3:0]  fexp;
  } tv_t;

  tv_t vecs [8];

  task automatic wr_vec(input int i, input tv_t v);
    wr_en0  = 1'b1;
    wr_en3  = 1'b1;
    wr_addr = i[AW-1:0];
    wr_data = {v.x, v.y, v.z, v.ctrl, v.rexp, v.fexp};
    tick();
    wr_en0 = 1'b0;
    wr_en3 = 1'b0;
  endtask

  // Pulse start, then step until done or the cycle budget runs out.
  // dt = cycles from the start cycle to the first done cycle.
  task automatic run(input bit sel, input int n, output int dt, output int vcnt,
                     output logic busy1);
    use3        = sel;
    num_vectors = n[AW:0];
    start0      = !sel;
    start3      = sel;
    tick();
    start0 = 1'b0;
    start3 = 1'b0;
    dt     = 1;
    vcnt   = 0;
    busy1  = s_busy;
    while (!s_done && dt < 100) begin
      if (s_val) vcnt++;
      tick();
      dt++;
    end
  endtask

  typedef struct {
    bit          sel;
    int          n;
    logic [3:0]  mask;
    bit          stop;
    logic [3:0]  fexp0;
    bit          ovr;
    logic [15:0] ox, ov;
    int          e_err, e_cnt, e_fidx;
    logic [15:0] e_fres;
    logic [3:0]  e_ffl;
    int          e_done, e_val;
  } case_t;

  case_t cases [12];

  initial begin
    int dt, vc;
    logic b1;

    reset = 1'b1; wr_en0 = 1'b0; wr_en3 = 1'b0; wr_addr = '0; wr_data = '0;
    num_vectors = '0; flag_mask = '0; stop_on_error = 1'b0;
    start0 = 1'b0; start3 = 1'b0; ovr_en = 1'b0; ovr_x = '0; ovr_val = '0; use3 = 1'b0;

    vecs[0] = '{16'h3c00, 16'h3c00, 16'h0000, 8'h08, 16'h3c00, 4'h0};
    vecs[1] = '{16'h4000, 16'h4200, 16'h0000, 8'h08, 16'h4600, 4'h0};
    for (int i = 2; i < 8; i++)
      vecs[i] = '{16'h1000 + 16'(i), 16'h0200 + 16'(i), 16'h0030 + 16'(i), 8'hF5,
                  16'h1230 | 16'(i), 4'(i)};

    //          sel n  mask  stp f0    ovr ox        ov        err cnt fidx fres      ffl   done val
    cases[0]  = '{0, 2, 4'h0, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 2, 0, 16'h0000, 4'h0, 4,  2};
    cases[1]  = '{0, 2, 4'h0, 0, 4'h0, 1, 16'h4000, 16'h4400, 1, 2, 1, 16'h4400, 4'h0, 4,  2};
    cases[2]  = '{0, 2, 4'h1, 0, 4'h1, 0, 16'h0000, 16'h0000, 1, 2, 0, 16'h3c00, 4'h0, 4,  2};
    cases[3]  = '{0, 2, 4'h0, 0, 4'h1, 0, 16'h0000, 16'h0000, 0, 2, 0, 16'h0000, 4'h0, 4,  2};
    cases[4]  = '{0, 8, 4'hF, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 8, 0, 16'h0000, 4'h0, 10, 8};
    cases[5]  = '{0, 8, 4'hF, 0, 4'h0, 1, 16'h1002, 16'h1233, 1, 8, 2, 16'h1233, 4'h2, 10, 8};
    cases[6]  = '{0, 8, 4'hF, 1, 4'h0, 1, 16'h1002, 16'h1233, 1, 3, 2, 16'h1233, 4'h2, 6,  3};
    cases[7]  = '{1, 8, 4'hF, 1, 4'h0, 1, 16'h1002, 16'h1233, 1, 6, 2, 16'h1233, 4'h2, 11, 6};
    cases[8]  = '{1, 8, 4'hF, 0, 4'h0, 1, 16'h1002, 16'h1233, 1, 8, 2, 16'h1233, 4'h2, 13, 8};
    cases[9]  = '{1, 2, 4'h0, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 2, 0, 16'h0000, 4'h0, 7,  2};
    cases[10] = '{0, 0, 4'hF, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 4'h0, 1,  0};
    cases[11] = '{1, 0, 4'hF, 0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 4'h0, 1,  0};

    tick();
    tick();
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_done0", 32'(done0), 0);
    chk("rst_err0", err0, 0);
    chk("rst_cnt0", 32'(cnt0), 0);
    chk("rst_x0", 32'(x0), 0);
    chk("rst_val0", 32'(val0), 0);
    chk("rst_fidx0", 32'(fidx0), 0);
    chk("rst_done3", 32'(done3), 0);
    chk("rst_busy3", 32'(busy3), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) wr_vec(i, vecs[i]);

    for (int c = 0; c < 12; c++) begin
      tv_t v0;
      v0      = vecs[0];
      v0.fexp = cases[c].fexp0;
      wr_vec(0, v0);
      flag_mask     = cases[c].mask;
      stop_on_error = cases[c].stop;
      ovr_en        = cases[c].ovr;
      ovr_x         = cases[c].ox;
      ovr_val       = cases[c].ov;
      run(cases[c].sel, cases[c].n, dt, vc, b1);
      chk($sformatf("c%0d_busy_t1", c), 32'(b1), 32'(cases[c].n != 0));
      chk($sformatf("c%0d_done_t", c), dt, cases[c].e_done);
      chk($sformatf("c%0d_errors", c), s_err, cases[c].e_err);
      chk($sformatf("c%0d_vec_count", c), 32'(s_cnt), cases[c].e_cnt);
      chk($sformatf("c%0d_dut_valid_cycles", c), vc, cases[c].e_val);
      chk($sformatf("c%0d_first_idx", c), 32'(s_fidx), cases[c].e_fidx);
      chk($sformatf("c%0d_first_res", c), 32'(s_fres), 32'(cases[c].e_fres));
      chk($sformatf("c%0d_first_flags", c), 32'(s_ffl), 32'(cases[c].e_ffl));
    end

    // Restart request and RAM write while busy must both be ignored;
    // also spot-check operand timing and ctrl decode.
    wr_vec(0, vecs[0]);
    ovr_en = 1'b0; flag_mask = 4'hF; stop_on_error = 1'b0;
    use3 = 1'b0; num_vectors = 5'd8;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    dt = 1;
    while (!done0 && dt < 100) begin
      if (dt == 2) begin
        chk("h1_x_at_t2", 32'(x0), 32'h3c00);
        chk("h1_valid_at_t2", 32'(val0), 1);
        chk("h1_mul_at_t2", 32'(mul0), 1);
        start0 = 1'b1;
      end
      if (dt == 4) begin
        wr_en0  = 1'b1;
        wr_addr = 4'd1;
        wr_data = {16'h4000, 16'h4200, 16'h0000, 8'h08, 16'hFFFF, 4'h0};
      end
      if (dt == 5) begin
        chk("h1_x_at_t5", 32'(x0), 32'h1003);
        chk("h1_ctrl_at_t5", 32'({rm0, mul0, add0, negp0, negz0}), 32'b11_0101);
        chk("h1_err_at_t5", err0, 0);
      end
      tick();
      start0 = 1'b0;
      wr_en0 = 1'b0;
      dt++;
    end
    chk("h1_done_t", dt, 10);
    chk("h1_cnt", 32'(cnt0), 8);
    chk("h1_err", err0, 0);

    run(1'b0, 2, dt, vc, b1);
    chk("h2_err_write_dropped", err0, 0);
    chk("h2_cnt", 32'(cnt0), 2);

    // Reset in the middle of a run.
    use3 = 1'b0; num_vectors = 5'd8;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick(); tick(); tick(); tick();
    chk("h3_cnt_at_t5", 32'(cnt0), 3);
    reset = 1'b1;
    tick();
    chk("h3_busy_after_rst", 32'(busy0), 0);
    chk("h3_cnt_after_rst", 32'(cnt0), 0);
    chk("h3_x_after_rst", 32'(x0), 0);
    chk("h3_valid_after_rst", 32'(val0), 0);
    chk("h3_done_after_rst", 32'(done0), 0);
    reset = 1'b0;
    tick();
    run(1'b0, 8, dt, vc, b1);
    chk("h3_rerun_done_t", dt, 10);
    chk("h3_rerun_err", err0, 0);
    chk("h3_rerun_cnt", 32'(cnt0), 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
